// File: rtl/fir_start_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_start_sequencer
// Description : Upstream ap_ctrl_hs driver for the fir_optimized core.
//               Queues input samples, issues one start per sample, captures
//               the filter result into a held output register and tracks
//               transaction count, latency statistics and a timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_start_sequencer #(
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 32,
  parameter int DEPTH   = 16,
  parameter int LAT_W   = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     fir_ap_start,
  input  logic                     fir_ap_ready,
  input  logic                     fir_ap_done,
  output logic [DATA_W-1:0]        fir_x,
  input  logic [OUT_W-1:0]         fir_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         txn_count,
  output logic [LAT_W-1:0]         last_latency,
  output logic [LAT_W-1:0]         max_latency,
  output logic                     err_timeout
);

  localparam int                  c_PW      = $clog2(DEPTH);
  localparam logic [c_PW:0]       c_FULL    = (c_PW+1)'(DEPTH);
  localparam logic [LAT_W-1:0]    c_TIMEOUT = LAT_W'(TIMEOUT);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_PW:0]     r_level;
  logic [1:0]        r_state;
  logic [LAT_W-1:0]  r_lat;
  logic              r_out_valid;
  logic [OUT_W-1:0]  r_out_data;
  logic [CNT_W-1:0]  r_txn;
  logic [LAT_W-1:0]  r_last_lat;
  logic [LAT_W-1:0]  r_max_lat;
  logic              r_err;

  logic              w_push;
  logic              w_pop;
  logic              w_capture;
  logic              w_abort;
  logic              w_launch;
  logic [LAT_W-1:0]  w_lat_next;

  // Handshake decode: FIFO push/pop, result capture, timeout abort, new launch
  always_comb begin
    w_push     = in_valid && in_ready;
    w_pop      = (r_state == c_START) && fir_ap_ready;
    w_capture  = ((r_state == c_START) && fir_ap_ready && fir_ap_done) ||
                 ((r_state == c_WAIT) && fir_ap_done);
    // A START cycle that is accepted is never aborted; the sample is gone.
    w_abort    = !w_capture && (r_lat >= c_TIMEOUT) &&
                 (((r_state == c_START) && !fir_ap_ready) || (r_state == c_WAIT));
    // Launch only when any held result will be gone before the next capture.
    w_launch   = (r_state == c_IDLE) && (r_level != '0) && (!r_out_valid || out_ready);
    w_lat_next = (r_lat == '1) ? r_lat : r_lat + 1'b1;
  end

  assign in_ready     = (r_level != c_FULL) && !reset;
  assign fir_ap_start = (r_state == c_START);
  assign fir_x        = (r_state == c_START) ? r_mem[r_rd_ptr] : '0;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign fifo_level   = r_level;
  assign txn_count    = r_txn;
  assign last_latency = r_last_lat;
  assign max_latency  = r_max_lat;
  assign err_timeout  = r_err;

  // Sample storage; contents need no reset since the pointers define validity
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Transaction FSM with start-to-done latency counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_lat   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_launch) begin
            r_state <= c_START;
            r_lat   <= LAT_W'(1);
          end
        end
        c_START: begin
          r_lat <= w_lat_next;
          if (w_capture || w_abort) r_state <= c_IDLE;
          else if (fir_ap_ready)    r_state <= c_WAIT;
        end
        c_WAIT: begin
          r_lat <= w_lat_next;
          if (w_capture || w_abort) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Result register, statistics and sticky timeout flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_txn       <= '0;
      r_last_lat  <= '0;
      r_max_lat   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_out_data  <= fir_y;
        r_txn       <= r_txn + 1'b1;
        r_last_lat  <= r_lat;
        if (r_lat > r_max_lat) r_max_lat <= r_lat;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_abort) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_start_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_start_sequencer
// Description : Scoreboard bench for fir_start_sequencer with a behavioural
//               ap_ctrl_hs core model (y = 3*x + 7).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_start_sequencer;

  localparam int DW = 16;
  localparam int OW = 32;
  localparam int DEPTH = 16;
  localparam int LW = 16;
  localparam int CW = 32;
  localparam int TO = 1024;

  logic                    clock;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [DW-1:0]           in_data;
  logic                    fir_ap_start;
  logic                    fir_ap_ready;
  logic                    fir_ap_done;
  logic [DW-1:0]           fir_x;
  logic [OW-1:0]           fir_y;
  logic                    out_valid;
  logic                    out_ready;
  logic [OW-1:0]           out_data;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic [CW-1:0]           txn_count;
  logic [LW-1:0]           last_latency;
  logic [LW-1:0]           max_latency;
  logic                    err_timeout;

  fir_start_sequencer #(
    .DATA_W(DW), .OUT_W(OW), .DEPTH(DEPTH), .LAT_W(LW), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fir_ap_start(fir_ap_start), .fir_ap_ready(fir_ap_ready),
    .fir_ap_done(fir_ap_done), .fir_x(fir_x), .fir_y(fir_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .fifo_level(fifo_level),
    .txn_count(txn_count), .last_latency(last_latency), .max_latency(max_latency),
    .err_timeout(err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [OW-1:0] sb_q[$];

  // core model controls
  bit stall = 1'b0;
  bit never_done = 1'b0;
  int d_after = 4;
  bit busy = 1'b0;
  bit acc = 1'b0;
  bit done_q = 1'b0;
  int c = 0;
  int rc = 0;
  logic [DW-1:0] mx = '0;

  function automatic logic [OW-1:0] fir_f(input logic [DW-1:0] x);
    return OW'(x) * OW'(3) + OW'(7);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input bit expect_out);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("push_in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    if (expect_out) sb_q.push_back(fir_f(d));
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || fifo_level != 0 || fir_ap_start || busy) && n < budget) begin
      tick();
      n++;
    end
    chk(name, (n < budget), 1);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!fir_ap_start && n < 100) begin
      tick();
      n++;
    end
    chk(name, fir_ap_start, 1);
  endtask

  // Behavioural ap_ctrl_hs core: ready on the first unstalled start cycle,
  // done d_after cycles after acceptance unless never_done.
  initial begin
    fir_ap_ready = 1'b0;
    fir_ap_done  = 1'b0;
    fir_y        = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        busy = 1'b0;
        acc  = 1'b0;
        done_q = 1'b0;
      end else begin
        if (busy) c++;
        if (busy && (done_q || c > TO || (!acc && !fir_ap_start))) busy = 1'b0;
        if (!busy && fir_ap_start) begin
          busy = 1'b1;
          c    = 1;
          acc  = 1'b0;
          mx   = fir_x;
        end
      end
      fir_ap_ready = busy && fir_ap_start && !acc && !stall;
      if (fir_ap_ready) rc = c;
      fir_ap_done = busy && (acc || fir_ap_ready) && !never_done && (c == rc + d_after);
      if (fir_ap_ready) acc = 1'b1;
      done_q = fir_ap_done;
      fir_y  = fir_f(mx);
    end
  end

  // Scoreboard monitor: compare every accepted result against the queue head
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", out_data, 0);
        end else begin
          chk("out_data", out_data, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] tc;
    bit saw_start;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick(3);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ap_start", fir_ap_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_maxlat", max_latency, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // three samples, latency 5
    out_ready = 1'b1;
    d_after = 4;
    push(1, 1); push(2, 1); push(3, 1);
    drain("drain_basic", 200);
    chk("basic_txn", txn_count, 3);
    chk("basic_last_lat", last_latency, 5);
    chk("basic_max_lat", max_latency, 5);

    // fill the FIFO while the core is stalled
    stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(DW'(10 + i), 1);
    tick();
    chk("full_in_ready", in_ready, 0);
    chk("full_level", fifo_level, DEPTH);
    chk("full_ap_start", fir_ap_start, 1);
    chk("full_fir_x", fir_x, 10);
    tick(5);
    chk("full_fir_x_held", fir_x, 10);
    chk("full_ap_start_held", fir_ap_start, 1);
    stall = 1'b0;
    drain("drain_full", 400);
    chk("full_txn", txn_count, 19);
    chk("full_last_lat", last_latency, 5);

    // ready and done in the start cycle: one idle cycle between starts
    d_after = 0;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push(DW'(40 + i), 1);
    tick();
    chk("b2b_start_pre", fir_ap_start, 1);
    stall = 1'b0;
    tick();
    chk("b2b_idle_gap", fir_ap_start, 0);
    tick();
    chk("b2b_restart", fir_ap_start, 1);
    tick();
    chk("b2b_last_lat", last_latency, 1);
    drain("drain_b2b", 100);
    chk("b2b_txn", txn_count, 23);
    chk("b2b_last_lat_end", last_latency, 1);

    // output backpressure blocks further starts
    d_after = 2;
    out_ready = 1'b0;
    push(100, 1); push(101, 1);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        tick();
        n++;
      end
    end
    chk("bp_out_valid", out_valid, 1);
    saw_start = 1'b0;
    repeat (10) begin
      tick();
      if (fir_ap_start) saw_start = 1'b1;
    end
    chk("bp_no_start", saw_start, 0);
    chk("bp_out_data", out_data, fir_f(100));
    chk("bp_level", fifo_level, 1);
    out_ready = 1'b1;
    drain("drain_bp", 100);
    chk("bp_txn", txn_count, 25);
    chk("bp_last_lat", last_latency, 3);

    // timeout: core never finishes
    never_done = 1'b1;
    tc = txn_count;
    push(200, 0);
    wait_start("to_start_seen");
    tick(TO - 1);
    chk("to_err_early", err_timeout, 0);
    tick();
    chk("to_err_set", err_timeout, 1);
    chk("to_txn_same", txn_count, tc);
    never_done = 1'b0;
    d_after = 4;
    push(201, 1);
    drain("drain_after_to", 200);
    chk("to_txn_next", txn_count, tc + 1);
    chk("to_err_sticky", err_timeout, 1);
    chk("to_last_lat", last_latency, 5);

    // reset during WAIT with five samples queued
    d_after = 50;
    for (int i = 0; i < 6; i++) push(DW'(300 + i), 0);
    chk("wr_level_pre", fifo_level, 5);
    chk("wr_in_wait", fir_ap_start, 0);
    reset = 1'b1;
    tick();
    chk("wr_ap_start", fir_ap_start, 0);
    chk("wr_level", fifo_level, 0);
    chk("wr_txn", txn_count, 0);
    chk("wr_last_lat", last_latency, 0);
    chk("wr_max_lat", max_latency, 0);
    chk("wr_err", err_timeout, 0);
    chk("wr_out_valid", out_valid, 0);
    reset = 1'b0;
    tick(3);
    chk("wr_idle_after", fir_ap_start, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
